// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder sequencer.
//   NIBBLE_W : width of the shared ripple adder slice
//   state_t  : sequencer state encoding (2'd3 is unreachable and decodes as IDLE)
package nibble_serial_adder_ctrl_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_adder_ctrl_if.sv
// Operand/result handshake bundle for nibble_serial_adder_ctrl.
//   in_valid/in_ready, a, b, cin          : operand request channel
//   out_valid/out_ready, sum, cout, ovf   : result channel
//   busy                                  : sequencer is in RUN or DONE
// slave  : the adder block
// master : the requester/consumer
interface nibble_serial_adder_ctrl_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf, busy
    );

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, busy
    );
endinterface

// File: rtl/ripple_adder.sv
// 4-bit ripple-carry adder slice.
//   Cin  : carry in
//   A, B : 4-bit addends
//   Cout : carry out of bit 3
//   S    : 4-bit sum
module ripple_adder
    import nibble_serial_adder_ctrl_pkg::*;
(
    input  logic                Cin,
    input  logic [NIBBLE_W-1:0] A,
    input  logic [NIBBLE_W-1:0] B,
    output logic                Cout,
    output logic [NIBBLE_W-1:0] S
);
    logic [NIBBLE_W:0] c;

    assign c[0] = Cin;

    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
        assign S[i]   = A[i] ^ B[i] ^ c[i];
        assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end

    assign Cout = c[NIBBLE_W];
endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial WIDTH-bit adder: one shared 4-bit ripple adder walks the
// operands LSB nibble first, one nibble per clock, with the carry held in a
// register between nibbles.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of the operand/result handshake bundle
//              (in_valid/in_ready/a/b/cin in, out_valid/out_ready/sum/cout/ovf
//              out, busy while RUN or DONE)
module nibble_serial_adder_ctrl
    import nibble_serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    nibble_serial_adder_ctrl_if.slave    bus
);
    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
        $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 4");
    end

    // Signed overflow: like-signed operands producing an opposite-signed sum.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb,
                                     input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    state_t               state;
    state_t               state_nxt;
    logic [IDX_W-1:0]     index;
    logic [WIDTH-1:0]     a_r;
    logic [WIDTH-1:0]     b_r;
    logic [WIDTH-1:0]     sum_r;
    logic                 carry_r;
    logic                 ovf_r;

    logic                 idle_dec;
    logic                 accept;
    logic                 last_nib;
    logic [IDX_W+1:0]     bitpos;
    logic [NIBBLE_W-1:0]  a_nib;
    logic [NIBBLE_W-1:0]  b_nib;
    logic [NIBBLE_W-1:0]  s_nib;
    logic                 c_nib;

    // The unused encoding behaves exactly like IDLE.
    assign idle_dec = (state != RUN) && (state != DONE);
    assign accept   = idle_dec && bus.in_valid;
    assign last_nib = (index == LAST_IDX);

    // Nibble mux: bit offset of the current nibble is index*4.
    assign bitpos = {index, 2'b00};
    assign a_nib  = a_r[bitpos +: NIBBLE_W];
    assign b_nib  = b_r[bitpos +: NIBBLE_W];

    ripple_adder u_ripple_adder (
        .Cin  (carry_r),
        .A    (a_nib),
        .B    (b_nib),
        .Cout (c_nib),
        .S    (s_nib)
    );

    // ---- state register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---- next-state decode ----
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.in_valid)  state_nxt = RUN;
            RUN:  if (last_nib)      state_nxt = DONE;
            DONE: if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = bus.in_valid ? RUN : IDLE;
        endcase
    end

    // ---- operand latch, nibble walk and result demux ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            index   <= '0;
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            carry_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else if (accept) begin
            index   <= '0;
            a_r     <= bus.a;
            b_r     <= bus.b;
            sum_r   <= '0;
            carry_r <= bus.cin;
        end else if (state == RUN) begin
            sum_r[bitpos +: NIBBLE_W] <= s_nib;
            carry_r                   <= c_nib;
            if (last_nib) begin
                // The top nibble is being written on this edge, so its MSB
                // comes straight from the adder rather than from sum_r.
                ovf_r <= add_ovf(a_r[WIDTH-1], b_r[WIDTH-1], s_nib[NIBBLE_W-1]);
            end else begin
                index <= index + 1'b1;
            end
        end
    end

    assign bus.in_ready  = idle_dec;
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state == RUN) || (state == DONE);
    assign bus.sum       = sum_r;
    assign bus.cout      = carry_r;
    assign bus.ovf       = ovf_r;

endmodule
